alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter n, default 32, the operand/result width.
REQ-002 SHALL have parameter MULT_LAT, default 3, the EXEC cycles for multiply (>=1).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-006 SHALL have port req_ready  output  2  per-requester accept strobe.
REQ-007 SHALL have port req_op1  input  2 x n  first operand per requester.
REQ-008 SHALL have port req_op2  input  2 x n  second operand per requester.
REQ-009 SHALL have port req_sel  input  2 x 2  operation per requester (00 add, 01 sub, 10 mult, 11 illegal).
REQ-010 SHALL have port rsp_valid  output  2  result valid, one-hot to the owning requester.
REQ-011 SHALL have port rsp_ready  input  2  per-requester result consume.
REQ-012 SHALL have port rsp_result  output  n  registered result, shared by both requesters.
REQ-013 SHALL have port rsp_zero  output  1  registered zero flag of rsp_result.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-015 In IDLE with any req_valid set, SHALL grant one requester, assert its req_ready combinationally that cycle, latch its op1/op2/sel/index, and enter EXEC.
REQ-016 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted last; single request is granted immediately.
REQ-017 req_ready SHALL be 0 outside IDLE and for the non-granted requester; a request stays pending until accepted.
REQ-018 EXEC SHALL last 1 cycle for add/sub/illegal and MULT_LAT cycles for mult, counted by an internal down-counter.
REQ-019 On the last EXEC cycle SHALL register ALU output into rsp_result/rsp_zero and enter RESP.
REQ-020 Latency: accepted in cycle T, rsp_valid SHALL rise at T+2 (add/sub) or T+1+MULT_LAT (mult).
REQ-021 In RESP, rsp_valid[owner] SHALL be held with stable result/zero until rsp_ready[owner]=1; then return to IDLE and update the last-grant pointer.
REQ-022 rsp_ready of the non-owner SHALL be ignored; a new request SHALL NOT be accepted in the RESP-exit cycle (accepted no earlier than next cycle).
REQ-023 Arithmetic SHALL be modulo 2^n (carry/overflow discarded; mult keeps low n bits); sel=11 yields result 0, zero=1.
REQ-024 Operand changes on req_* after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-025 rst SHALL force IDLE, req_ready=0 (registered part), rsp_valid=00, rsp_result=0, rsp_zero=0, counter=0, last-grant pointer=1 (requester 0 wins first tie).
REQ-026 rst asserted mid-EXEC or mid-RESP SHALL abort the operation with no response issued.

Configuration
REQ-027 With macro ALU_ARB_ILLEGAL_ERR_EN defined, SHALL add output rsp_err (1 bit), set to 1 with a sel=11 response and 0 otherwise, reset 0; without it, rsp_err SHALL NOT exist and sel=11 behaves per REQ-023 only.

Structure
REQ-028 A shared package SHALL hold the op encoding enum (ADD, SUB, MULT, ILLEGAL) and the FSM state enum.
REQ-029 SHALL instantiate exactly one sub-module, the existing ALU (parameter n), fed from the latched operands.

Verification
REQ-030 Reset: rst=1 mid-mult -> after release rsp_valid=00, state IDLE, no response.
REQ-031 Single add: req 0, op1=5, op2=7, sel=00 at T -> rsp_valid=01 at T+2, result=12, zero=0.
REQ-032 Mult latency, MULT_LAT=3: req 1, 6x7 at T -> rsp_valid=10 at T+4, result=42; held 3 cycles with rsp_ready=0, stable.
REQ-033 Tie: both valid, sub 3-3 and add 1+1 -> requester 0 first (result 0, zero=1), then requester 1 (result 2); next tie grants 1 first.
REQ-034 Wrap: add 0xFFFFFFFF+1 -> result 0, zero=1; mult 0x80000000x2 -> 0.
REQ-035 Illegal sel=11 with ALU_ARB_ILLEGAL_ERR_EN -> result 0, zero=1, rsp_err=1; without macro -> same result, no rsp_err port.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter: operation encoding and FSM states.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ADD     = 2'b00,
    SUB     = 2'b01,
    MULT    = 2'b10,
    ILLEGAL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  function automatic logic [1:0] idx2oh(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: modulo-2^n add/sub/mult; the illegal encoding yields zero.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [n-1:0] op1_i,
  input  logic [n-1:0] op2_i,
  input  op_e          sel_i,
  output logic [n-1:0] result_o,
  output logic         zero_o
);

  always_comb begin
    result_o = '0;
    case (sel_i)
      ADD:     result_o = op1_i + op2_i;
      SUB:     result_o = op1_i - op2_i;
      MULT:    result_o = op1_i * op2_i;
      default: result_o = '0;
    endcase
    zero_o = (result_o == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters (IDLE/EXEC/RESP).
// Optional rsp_err output for sel=11 when ALU_ARB_ILLEGAL_ERR_EN is defined.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int n        = 32,
  parameter int MULT_LAT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0][n-1:0]   req_op1,
  input  logic [1:0][n-1:0]   req_op2,
  input  logic [1:0][1:0]     req_sel,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [n-1:0]        rsp_result,
  output logic                rsp_zero
`ifdef ALU_ARB_ILLEGAL_ERR_EN
  ,output logic               rsp_err
`endif
);

  localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [n-1:0]     result_q, result_d;
  logic             zero_q, zero_d;
`ifdef ALU_ARB_ILLEGAL_ERR_EN
  logic             err_q, err_d;
`endif

  logic [n-1:0]     op1_q, op2_q;
  op_e              sel_q;
  logic             gnt_idx;
  logic             accept;
  logic [n-1:0]     alu_result;
  logic             alu_zero;

  // On a tie the requester not granted last wins; a lone request wins outright.
  always_comb begin
    gnt_idx   = (req_valid == 2'b11) ? ~last_q : req_valid[1];
    accept    = (state_q == IDLE) && (|req_valid);
    req_ready = accept ? idx2oh(gnt_idx) : 2'b00;
  end

  alu_arbiter_alu #(.n(n)) u_alu (
    .op1_i    (op1_q),
    .op2_i    (op2_q),
    .sel_i    (sel_q),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    last_d   = last_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifdef ALU_ARB_ILLEGAL_ERR_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = EXEC;
          owner_d = gnt_idx;
          cnt_d   = (op_e'(req_sel[gnt_idx]) == MULT) ? CNT_W'(MULT_LAT - 1) : '0;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_d  = RESP;
          result_d = alu_result;
          zero_d   = alu_zero;
`ifdef ALU_ARB_ILLEGAL_ERR_EN
          err_d    = (sel_q == ILLEGAL);
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      result_q <= '0;
      zero_q   <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifdef ALU_ARB_ILLEGAL_ERR_EN
      err_q    <= err_d;
`endif
    end
  end

  // Operands are captured at acceptance so later req_* changes cannot disturb the op.
  always_ff @(posedge clk) begin
    if (accept) begin
      op1_q <= req_op1[gnt_idx];
      op2_q <= req_op2[gnt_idx];
      sel_q <= op_e'(req_sel[gnt_idx]);
    end
  end

  assign rsp_valid  = (state_q == RESP) ? idx2oh(owner_q) : 2'b00;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
`ifdef ALU_ARB_ILLEGAL_ERR_EN
  assign rsp_err    = err_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic against a
// transaction-level timing/arithmetic model.
module tb_alu_arbiter;

  localparam int N  = 32;
  localparam int ML = 3;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [1:0]   sel;
  } txn_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0][N-1:0] req_op1, req_op2;
  logic [1:0][1:0]  req_sel;
  logic [N-1:0]     rsp_result;
  logic             rsp_zero;
`ifdef ALU_ARB_ILLEGAL_ERR_EN
  logic             rsp_err;
`endif

  always #5 clk = ~clk;

  alu_arbiter #(.n(N), .MULT_LAT(ML)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .req_sel    (req_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
`ifdef ALU_ARB_ILLEGAL_ERR_EN
    ,.rsp_err   (rsp_err)
`endif
  );

  txn_t  q [2][$];
  int    checks = 0;
  int    failures = 0;
  int    c = 0;
  int    hold = 0;
  string phase = "reset";

  // Model of the arbiter at transaction level.
  bit           m_busy = 1'b0;
  bit           m_owner = 1'b0;
  bit           m_last = 1'b1;
  int           m_resp_at = 0;
  int           m_idle_from = 0;
  logic [N-1:0] m_res = '0;
  bit           m_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s/%s cycle=%0d got=%0h exp=%0h", phase, tag, c, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] ref_alu(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [1:0] sel);
    logic [2*N-1:0] full;
    case (sel)
      2'd0: return a + b;
      2'd1: return a - b;
      2'd2: begin
        full = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        return full[N-1:0];
      end
      default: return '0;
    endcase
  endfunction

  function automatic logic [N-1:0] rand_op();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  task automatic push(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [1:0] sel);
    txn_t t;
    t.a = a; t.b = b; t.sel = sel;
    q[i].push_back(t);
  endtask

  task automatic step();
    logic [1:0] rr, exp_rdy, exp_rv;
    bit         g;
    txn_t       t;
    @(posedge clk); #1;
    c++;
    for (int i = 0; i < 2; i++) begin
      if (q[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_op1[i]   = q[i][0].a;
        req_op2[i]   = q[i][0].b;
        req_sel[i]   = q[i][0].sel;
      end else begin
        req_valid[i] = 1'b0;
        req_op1[i]   = $urandom;
        req_op2[i]   = $urandom;
        req_sel[i]   = 2'($urandom_range(0, 3));
      end
    end
    rr = 2'($urandom_range(0, 3));
    if (m_busy && c >= m_resp_at && hold >= 0) rr[m_owner] = ((c - m_resp_at) >= hold);
    rsp_ready = rr;
    @(negedge clk);
    exp_rdy = 2'b00;
    g = 1'b0;
    if (!m_busy && c >= m_idle_from && req_valid != 2'b00) begin
      g = (req_valid == 2'b11) ? ~m_last : req_valid[1];
      exp_rdy = g ? 2'b10 : 2'b01;
    end
    exp_rv = (m_busy && c >= m_resp_at) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    if (exp_rv != 2'b00) begin
      chk("rsp_result", 64'(rsp_result), 64'(m_res));
      chk("rsp_zero", 64'(rsp_zero), 64'(m_res == '0));
`ifdef ALU_ARB_ILLEGAL_ERR_EN
      chk("rsp_err", 64'(rsp_err), 64'(m_err));
`endif
      if (rsp_ready[m_owner]) begin
        m_busy      = 1'b0;
        m_last      = m_owner;
        m_idle_from = c + 1;
      end
    end
    if (exp_rdy != 2'b00) begin
      t = q[g].pop_front();
      m_busy    = 1'b1;
      m_owner   = g;
      m_res     = ref_alu(t.a, t.b, t.sel);
      m_err     = (t.sel == 2'b11);
      m_resp_at = c + ((t.sel == 2'b10) ? 1 + ML : 2);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_op1 = '0;
    req_op2 = '0;
    req_sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_result", 64'(rsp_result), 64'd0);
    chk("rst_zero", 64'(rsp_zero), 64'd0);
`ifdef ALU_ARB_ILLEGAL_ERR_EN
    chk("rst_err", 64'(rsp_err), 64'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    phase = "add";
    push(0, 32'd5, 32'd7, 2'b00);
    hold = 0;
    repeat (6) step();

    phase = "mult";
    push(1, 32'd6, 32'd7, 2'b10);
    hold = 3;
    repeat (12) step();

    phase = "tie";
    push(0, 32'd3, 32'd3, 2'b01);
    push(1, 32'd1, 32'd1, 2'b00);
    push(0, 32'd2, 32'd2, 2'b00);
    hold = 1;
    repeat (20) step();

    phase = "wrap";
    push(0, 32'hFFFF_FFFF, 32'd1, 2'b00);
    push(1, 32'h8000_0000, 32'd2, 2'b10);
    hold = 0;
    repeat (16) step();

    phase = "illegal";
    push(1, 32'd1234, 32'd5678, 2'b11);
    repeat (6) step();

    phase = "abort";
    push(1, 32'd6, 32'd7, 2'b10);
    for (int k = 0; k < 10 && !m_busy; k++) step();
    chk("abort_accepted", 64'(m_busy), 64'd1);
    step();
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 2'b00;
    q[0].delete();
    q[1].delete();
    m_busy = 1'b0;
    m_last = 1'b1;
    m_idle_from = 0;
    #1;
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    chk("abort_result", 64'(rsp_result), 64'd0);
    rst = 1'b0;
    repeat (8) step();
    push(0, 32'd9, 32'd4, 2'b01);
    repeat (6) step();

    phase = "random";
    hold = -1;
    repeat (3000) begin
      for (int i = 0; i < 2; i++)
        if (q[i].size() == 0 && $urandom_range(0, 3) == 0)
          push(i, rand_op(), rand_op(), 2'($urandom_range(0, 3)));
      step();
    end

    phase = "drain";
    hold = 0;
    repeat (40) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
